// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin search used by the AXI-Stream packet arbiters.
// The search is sized for up to MAX_IN requesters; callers pass their real count.
package axis_arb_pkg;

    localparam int MAX_IN    = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic {
        IDLE,
        PASS
    } arb_state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    // First set bit of req at or after ptr, wrapping modulo n.
    function automatic pick_t rr_pick(
        input logic [MAX_IN-1:0]    req,
        input logic [MAX_IDX_W-1:0] ptr,
        input int                   n
    );
        pick_t res;
        int    cand;
        res.found = 1'b0;
        res.idx   = '0;
        for (int off = 0; off < MAX_IN; off++) begin
            cand = int'(ptr) + off;
            if (cand >= n) cand = cand - n;
            if (off < n && !res.found && req[cand[MAX_IDX_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = cand[MAX_IDX_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin priority picker: N_IN request bits and a start pointer
// in, one-hot grant, binary index and found flag out.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int IDX_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_IN-1:0]  gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             found
);

    logic [MAX_IN-1:0]    req_ext;
    logic [MAX_IDX_W-1:0] ptr_ext;
    pick_t                res;

    // NOTE: every signal written in always_comb is given a default first so no
    // path leaves it unassigned, which is what keeps latches from being inferred.
    always_comb begin
        req_ext             = '0;
        req_ext[N_IN-1:0]   = req;
        ptr_ext             = '0;
        ptr_ext[IDX_W-1:0]  = ptr;
        res                 = rr_pick(req_ext, ptr_ext, N_IN);
        found               = res.found;
        gnt_idx             = res.idx[IDX_W-1:0];
        gnt_onehot          = '0;
        if (res.found) gnt_onehot[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter: the grant is held from first beat to
// tlast. Define AXIS_ARB_SRCID_EN to add the m_tid source-index output.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int N_IN   = 4,
    parameter  int BYTES  = 1,
    parameter  int USER_W = 1,
    localparam int IDX_W  = $clog2(N_IN)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_IN*BYTES*8-1:0] s_tdata,
    input  logic [N_IN-1:0]         s_tvalid,
    input  logic [N_IN-1:0]         s_tlast,
    input  logic [N_IN*USER_W-1:0]  s_tuser,
    output logic [N_IN-1:0]         s_tready,
    output logic [BYTES*8-1:0]      m_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    output logic [USER_W-1:0]       m_tuser,
    input  logic                    m_tready,
`ifdef AXIS_ARB_SRCID_EN
    output logic [IDX_W-1:0]        m_tid,
`endif
    output logic [N_IN-1:0]         grant,
    output logic [31:0]             pkt_cnt
);

    localparam int DATA_W = BYTES * 8;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_IN-1:0]  grant_q, grant_d;
    logic [31:0]      pkt_cnt_q, pkt_cnt_d;

    logic [N_IN-1:0]  pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    axis_rr_pick #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_pick (
        .req        (s_tvalid),
        .ptr        (ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .found      (pick_found)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        pkt_cnt_d = pkt_cnt_q;
        m_tdata   = '0;
        m_tuser   = '0;
        m_tlast   = 1'b0;
        m_tvalid  = 1'b0;
        s_tready  = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = PASS;
                    owner_d = pick_idx;
                    grant_d = pick_onehot;
                end
            end
            PASS: begin
                m_tdata            = s_tdata[int'(owner_q)*DATA_W +: DATA_W];
                m_tuser            = s_tuser[int'(owner_q)*USER_W +: USER_W];
                m_tlast            = s_tlast[owner_q];
                m_tvalid           = s_tvalid[owner_q];
                s_tready[owner_q]  = m_tready;
                // Only the tlast handshake releases the owner; a stalled source keeps it.
                if (m_tvalid && m_tready && m_tlast) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    ptr_d     = (owner_q == IDX_W'(N_IN - 1)) ? '0 : owner_q + 1'b1;
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign grant   = grant_q;
    assign pkt_cnt = pkt_cnt_q;

`ifdef AXIS_ARB_SRCID_EN
    assign m_tid = (state_q == PASS) ? owner_q : '0;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: a 4-input instance driven by simple packet
// sources, plus a 3-input instance for the pointer wrap case.
module tb_axis_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid, s_tlast, s_tuser, s_tready, grant;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [0:0]  m_tuser;
    logic [31:0] pkt_cnt;
`ifdef AXIS_ARB_SRCID_EN
    logic [1:0]  m_tid;
    logic [1:0]  w_m_tid;
`endif

    logic [23:0] w_tdata;
    logic [2:0]  w_tvalid, w_tlast, w_tuser, w_tready, w_grant;
    logic [7:0]  w_m_tdata;
    logic        w_m_tvalid, w_m_tlast, w_m_tready;
    logic [0:0]  w_m_tuser;
    logic [31:0] w_pkt_cnt;

    always #5 clk = ~clk;

    axis_rr_arbiter #(.N_IN(4), .BYTES(1), .USER_W(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .m_tready(m_tready),
`ifdef AXIS_ARB_SRCID_EN
        .m_tid(m_tid),
`endif
        .grant(grant), .pkt_cnt(pkt_cnt)
    );

    axis_rr_arbiter #(.N_IN(3), .BYTES(1), .USER_W(1)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .s_tdata(w_tdata), .s_tvalid(w_tvalid), .s_tlast(w_tlast), .s_tuser(w_tuser),
        .s_tready(w_tready),
        .m_tdata(w_m_tdata), .m_tvalid(w_m_tvalid), .m_tlast(w_m_tlast), .m_tuser(w_m_tuser),
        .m_tready(w_m_tready),
`ifdef AXIS_ARB_SRCID_EN
        .m_tid(w_m_tid),
`endif
        .grant(w_grant), .pkt_cnt(w_pkt_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packet source model: each input sends left[i] packets of plen[i] beats,
    // beat b of packet k carrying dbase[i] + 4*k + b.
    int         left[4], plen[4], beat[4], sent[4];
    logic [7:0] dbase[4];
    logic [3:0] stall;

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            s_tvalid[i]        = (left[i] > 0) && !stall[i];
            s_tdata[i*8 +: 8]  = dbase[i] + 8'(sent[i] * 4 + beat[i]);
            s_tlast[i]         = (beat[i] == plen[i] - 1);
            s_tuser[i]         = (beat[i] == 0);
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            left[i] = 0; plen[i] = 1; beat[i] = 0; sent[i] = 0; dbase[i] = '0;
        end
        stall = '0;
    endtask

    task automatic cyc();
        logic [3:0] x;
        x = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (x[i]) begin
                beat[i]++;
                if (beat[i] == plen[i]) begin
                    beat[i] = 0;
                    sent[i]++;
                    left[i]--;
                end
            end
        end
        drive();
        #1;
    endtask

    int         exp_g[5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_d[5] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h04};
    logic [3:0] oh;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b0;
        m_tready   = 1'b1;
        w_m_tready = 1'b1;
        w_tdata = '0; w_tvalid = '0; w_tlast = '0; w_tuser = '0;
        clear_src();
        drive();
        #1;
        check("rst_grant", grant, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_m_tdata", m_tdata, 0);

        // Contention: all four request 2-beat packets, input 0 has two.
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            left[i] = 1; plen[i] = 2; dbase[i] = 8'(i * 16);
        end
        left[0] = 2;
        drive();
        #1;
        check("cont_pre_grant", grant, 0);
        for (int p = 0; p < 5; p++) begin
            oh = 4'b0001 << exp_g[p];
            cyc();
            check($sformatf("cont%0d_grant", p), grant, oh);
            check($sformatf("cont%0d_tready", p), s_tready, oh);
            check($sformatf("cont%0d_d0", p), m_tdata, exp_d[p]);
            check($sformatf("cont%0d_user0", p), m_tuser, 1);
            cyc();
            check($sformatf("cont%0d_d1", p), m_tdata, exp_d[p] + 8'd1);
            check($sformatf("cont%0d_last", p), m_tlast, 1);
            cyc();
            check($sformatf("cont%0d_bubble", p), grant, 0);
            check($sformatf("cont%0d_bub_valid", p), m_tvalid, 0);
        end
        check("cont_pkt_cnt", pkt_cnt, 5);

        // Single source: input 2 sends 0xA1,0xA2,0xA3.
        clear_src();
        left[2] = 1; plen[2] = 3; dbase[2] = 8'hA1;
        drive();
        #1;
        check("single_pre_grant", grant, 0);
        cyc();
        check("single_grant", grant, 4'b0100);
        check("single_valid", m_tvalid, 1);
        check("single_d0", m_tdata, 8'hA1);
        check("single_tready", s_tready, 4'b0100);
        check("single_last0", m_tlast, 0);
        cyc();
        check("single_d1", m_tdata, 8'hA2);
        cyc();
        check("single_d2", m_tdata, 8'hA3);
        check("single_last2", m_tlast, 1);
        cyc();
        check("single_bubble", grant, 0);
        check("single_idle_valid", m_tvalid, 0);
        check("single_idle_data", m_tdata, 0);
        check("single_pkt_cnt", pkt_cnt, 6);

        // Reset mid-packet on input 3, then ptr must restart from 0.
        left[3] = 1; plen[3] = 4; dbase[3] = 8'hC0;
        drive();
        cyc();
        check("rmid_grant", grant, 4'b1000);
        cyc();
        check("rmid_d1", m_tdata, 8'hC1);
        reset_n = 1'b0;
        #1;
        check("rmid_rst_grant", grant, 0);
        check("rmid_rst_valid", m_tvalid, 0);
        check("rmid_rst_tready", s_tready, 0);
        check("rmid_rst_data", m_tdata, 0);
        check("rmid_rst_last", m_tlast, 0);
        check("rmid_rst_cnt", pkt_cnt, 0);
        clear_src();
        drive();
        @(posedge clk); #1;
        reset_n = 1'b1;
        left[1] = 1; dbase[1] = 8'h50;
        left[3] = 1; dbase[3] = 8'h70;
        drive();
        cyc();
        check("rmid_ptr0_grant", grant, 4'b0010);
        check("rmid_ptr0_data", m_tdata, 8'h50);
        check("rmid_ptr0_last", m_tlast, 1);
        cyc();
        check("rmid_bub1", grant, 0);
        cyc();
        check("rmid_g3", grant, 4'b1000);
        check("rmid_g3_data", m_tdata, 8'h70);
        cyc();
        check("rmid_cnt", pkt_cnt, 2);

        // Backpressure on input 1 while input 2 waits.
        clear_src();
        left[1] = 1; plen[1] = 3; dbase[1] = 8'h60;
        left[2] = 1; dbase[2] = 8'h90;
        drive();
        cyc();
        check("bp_grant", grant, 4'b0010);
        check("bp_tready_a", s_tready, 4'b0010);
        cyc();
        m_tready = 1'b0; #1;
        check("bp_tready_b", s_tready, 4'b0000);
        check("bp_data_b", m_tdata, 8'h61);
        cyc();
        check("bp_data_c", m_tdata, 8'h61);
        check("bp_tready_c", s_tready, 4'b0000);
        cyc();
        m_tready = 1'b1; #1;
        check("bp_data_d", m_tdata, 8'h61);
        check("bp_tready_d", s_tready, 4'b0010);
        cyc();
        check("bp_data_e", m_tdata, 8'h62);
        check("bp_last_e", m_tlast, 1);
        cyc();
        check("bp_bubble", grant, 0);
        check("bp_cnt", pkt_cnt, 3);
        cyc();
        check("bp_next_grant", grant, 4'b0100);
        check("bp_next_data", m_tdata, 8'h90);
        cyc();
        check("bp_cnt2", pkt_cnt, 4);

        // Stalled owner: input 0 drops tvalid for 10 cycles while input 3 waits.
        clear_src();
        left[0] = 1; plen[0] = 3; dbase[0] = 8'hE0;
        drive();
        cyc();
        check("stall_grant", grant, 4'b0001);
        cyc();
        stall[0] = 1'b1;
        left[3] = 1; dbase[3] = 8'hF0;
        drive();
        #1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            check($sformatf("stall%0d_grant", k), grant, 4'b0001);
            check($sformatf("stall%0d_valid", k), m_tvalid, 0);
        end
        stall[0] = 1'b0;
        drive();
        #1;
        check("stall_resume_data", m_tdata, 8'hE1);
        cyc();
        check("stall_last_data", m_tdata, 8'hE2);
        check("stall_last", m_tlast, 1);
        cyc();
        check("stall_bubble", grant, 0);
        cyc();
        check("stall_g3", grant, 4'b1000);
        check("stall_g3_data", m_tdata, 8'hF0);
        cyc();
        check("stall_cnt", pkt_cnt, 6);
        clear_src();
        drive();

        // Wrap on the 3-input instance: serve input 1 to set ptr=2.
        w_tvalid = 3'b010; w_tlast = 3'b010; w_tdata = 24'h00_11_00;
        @(posedge clk); #1;
        check("wrap_g1", w_grant, 3'b010);
        @(posedge clk); #1;
        w_tvalid = 3'b101; w_tlast = 3'b101; w_tdata = 24'h22_00_33;
        #1;
        check("wrap_bubble", w_grant, 0);
        @(posedge clk); #1;
        check("wrap_g2", w_grant, 3'b100);
        check("wrap_g2_data", w_m_tdata, 8'h22);
`ifdef AXIS_ARB_SRCID_EN
        check("wrap_tid2", w_m_tid, 2);
`endif
        @(posedge clk); #1;
        w_tvalid = 3'b011; w_tlast = 3'b011; w_tdata = 24'h00_44_33;
        #1;
        check("wrap_bubble2", w_grant, 0);
        @(posedge clk); #1;
        check("wrap_g0", w_grant, 3'b001);
        check("wrap_g0_data", w_m_tdata, 8'h33);
`ifdef AXIS_ARB_SRCID_EN
        check("wrap_tid0", w_m_tid, 0);
`endif
        @(posedge clk); #1;
        w_tvalid = '0;
        #1;
        check("wrap_cnt", w_pkt_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream slave among N_IN AXI-Stream masters. A grant is held from the first beat of a packet through its tlast beat, so packets are never interleaved on the output. The block sits between several stream producers (DMA channels, test generators) and a single consumer, and uses the same tdata/tvalid/tlast/tready/tuser signal set as the team's axi_stream_if.

## Interface
Parameters:
- N_IN, 4: number of input streams, 2..16
- BYTES, 1: tdata width in bytes
- USER_W, 1: tuser width
- IDX_W, $clog2(N_IN): index width (derived, not overridden)

Ports:
- clk  in  1  single clock, all logic on posedge
- reset_n  in  1  asynchronous active-low reset
- s_tdata  in  N_IN*BYTES*8  input data; stream i occupies slice i
- s_tvalid  in  N_IN  per-input valid
- s_tlast  in  N_IN  per-input end of packet
- s_tuser  in  N_IN*USER_W  per-input user; stream i occupies slice i
- s_tready  out  N_IN  per-input ready
- m_tdata  out  BYTES*8  output data
- m_tvalid  out  1  output valid
- m_tlast  out  1  output end of packet
- m_tuser  out  USER_W  output user
- m_tready  in  1  output ready
- grant  out  N_IN  one-hot current owner; 0 when idle
- pkt_cnt  out  32  number of packets forwarded

## Operation
- FSM states:
  - IDLE: no owner; grant=0, m_tvalid=0, all s_tready=0.
  - PASS: owner g.
- IDLE -> PASS: at the first posedge with any s_tvalid=1. g is the first requesting index found searching ptr, ptr+1, ..., N_IN-1, 0, ..., ptr-1.
- In PASS:
  - m_tdata, m_tuser, m_tlast and m_tvalid follow stream g combinationally.
  - s_tready[g]=m_tready; all other s_tready=0.
- A beat transfers when m_tvalid && m_tready.
- PASS -> IDLE: on a transfer with m_tlast=1. At the same edge:
  - ptr <= (g+1) mod N_IN, wrapping to 0 when g=N_IN-1, including non-power-of-2 N_IN;
  - pkt_cnt increments, wrapping 2^32-1 -> 0.
- Owner dropping s_tvalid mid-packet: grant is held indefinitely; no timeout and no preemption.
- A requester that is not granted must hold its data; its s_tready stays 0.
- Outputs in IDLE: m_tdata, m_tuser and m_tlast are driven to 0.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state=IDLE, ptr=0, grant=0, pkt_cnt=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tuser=0, s_tready=0.
- Arbitration latency: one cycle. A request seen at edge k produces grant and m_tvalid after edge k.
- Packet gap: exactly one IDLE bubble cycle after every tlast transfer, including back-to-back packets from the same or another source.
- Single-beat packet (tlast on the first beat) costs 2 cycles minimum per packet.
- Throughput within a packet: 1 beat/cycle when the source is valid and m_tready=1.
- Combinational paths: m_tready -> s_tready, and s_* -> m_*. There is no registered slice.
- Simultaneous requests: resolved by round-robin from ptr; fairness bound is N_IN-1 packets of wait.
- Reset mid-packet: the packet is truncated (no tlast emitted) and the grant is released immediately.

## Configuration
- AXIS_ARB_SRCID_EN defined:
  - extra output port m_tid [IDX_W-1:0] carries g during PASS and 0 in IDLE; reset value 0.
- Not defined:
  - port absent; behaviour otherwise identical.

## Structure
- Package axis_arb_pkg holds:
  - typedef arb_state_t enum {IDLE, PASS};
  - function rr_pick(req, ptr) returning index and found flag.
- One sub-module: axis_rr_pick, a combinational round-robin priority picker (N_IN request bits plus ptr in, one-hot plus index out). It is reusable by other arbiters.
- The top level holds the FSM, ptr, grant register, mux and pkt_cnt.

## Test plan
- Reset mid-packet: reset_n low during PASS -> all outputs return to their reset values within the same cycle; next packet starts from ptr=0.
- Single source: input 2 sends 3-beat packet 0xA1,0xA2,0xA3 with m_tready=1 -> grant=0b0100 one cycle after request; output 0xA1,0xA2,0xA3 with tlast on the 3rd beat; pkt_cnt=1; 1 bubble follows.
- Contention: all 4 inputs request at once, each sending 2-beat packets -> grant order 0,1,2,3,0; no interleaving; pkt_cnt=5 after 5 packets.
- Backpressure: m_tready toggles 1,0,0,1 during a packet -> s_tready[g] mirrors m_tready; no beat lost or duplicated; other s_tready stay 0.
- Stalled owner: owner deasserts tvalid for 10 cycles mid-packet while input 3 requests -> grant unchanged; input 3 is served only after the owner's tlast.
- Wrap: N_IN=3, ptr=2, inputs 0 and 2 request -> input 2 granted, then input 0; with AXIS_ARB_SRCID_EN, m_tid shows 2 then 0.
